// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel memory-to-memory DMA engine:
// control-register layout, register offsets, transfer sizes and FSM states.
package dma_pkg;

    typedef struct packed {
        logic [8:0]  rsv;
        logic        line_en;
        logic        inc_dst_a;
        logic        inc_src_a;
        logic [1:0]  dst_size;
        logic [1:0]  src_size;
        logic [15:0] cnt;
    } dma_cr_v;

    localparam logic [3:0] DMA_CR      = 4'h0;
    localparam logic [3:0] DMA_SRC_ADR = 4'h4;
    localparam logic [3:0] DMA_DST_ADR = 4'h8;
    localparam logic [3:0] DMA_SR      = 4'hC;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } dma_state_e;

    // Address advance per item; size code 11 behaves as a word.
    function automatic logic [31:0] size_step(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_step = 32'd1;
            SZ_H:    size_step = 32'd2;
            default: size_step = 32'd4;
        endcase
    endfunction

endpackage

// File: rtl/dma_core_if.sv
// Bundles the DMA's register-slave port and its bus-master port.
// Modport slave is the DMA's own view; modport master is the surrounding fabric's view.
interface dma_core_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  size;

    logic        bus_req;
    logic        bus_lock;
    logic        bus_grant;
    logic [31:0] addr_m;
    logic        we_m;
    logic [31:0] wd_m;
    logic [1:0]  size_m;
    logic [31:0] rd_m;

    modport slave (
        input  addr, we, wd, size, bus_grant, rd_m,
        output rd, bus_req, bus_lock, addr_m, we_m, wd_m, size_m
    );

    modport master (
        output addr, we, wd, size, bus_grant, rd_m,
        input  rd, bus_req, bus_lock, addr_m, we_m, wd_m, size_m
    );
endinterface

// File: rtl/dma_lane_mux.sv
// Byte-lane steering: pulls a zero-extended item out of the read bus and
// replicates the held item across the write-bus lanes for the destination size.
module dma_lane_mux
    import dma_pkg::*;
(
    input  logic [31:0] rd_m_i,
    input  logic [1:0]  rd_addr_i,
    input  logic [1:0]  rd_size_i,
    input  logic [31:0] item_i,
    input  logic [1:0]  wr_size_i,
    output logic [31:0] item_o,
    output logic [31:0] wd_m_o
);
    logic [7:0]  lane [4];
    logic [15:0] half [2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rd_m_i[8*gi +: 8];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign half[gi] = rd_m_i[16*gi +: 16];
    end

    always_comb begin
        case (rd_size_i)
            SZ_B:    item_o = {24'd0, lane[rd_addr_i]};
            SZ_H:    item_o = {16'd0, half[rd_addr_i[1]]};
            default: item_o = rd_m_i;
        endcase
    end

    // Replication lets the slave pick whichever lanes the address selects.
    always_comb begin
        case (wr_size_i)
            SZ_B:    wd_m_o = {4{item_i[7:0]}};
            SZ_H:    wd_m_o = {2{item_i[15:0]}};
            default: wd_m_o = item_i;
        endcase
    end
endmodule

// File: rtl/dma_core.sv
// Single-channel DMA: register block plus an IDLE/RD/WR engine that copies cnt+1
// items, holding the bus locked from the first read until the last write.
module dma_core
    import dma_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       dma_req,
    dma_core_if.slave  bus
);
    dma_state_e  state_q, state_d;
    dma_cr_v     cr_q;
    dma_cr_v     wcfg_q, wcfg_d;
    logic [31:0] src_q, dst_q;
    logic [31:0] wsrc_q, wsrc_d;
    logic [31:0] wdst_q, wdst_d;
    logic [31:0] item_q, item_d;
    logic [31:0] rd_item, wd_rep;
    logic [3:0]  reg_off;
    logic        busy;
    logic        unused_bits;

    logic        req_c, we_c;
    logic [31:0] addr_c, wd_c;
    logic [1:0]  size_c;

    assign reg_off     = {bus.addr[3:2], 2'b00};
    assign busy        = (state_q != ST_IDLE);
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.size, bus.wd[31:23], wcfg_q.rsv};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cr_q  <= '0;
            src_q <= '0;
            dst_q <= '0;
        end else if (bus.we) begin
            case (reg_off)
                DMA_CR:      cr_q  <= dma_cr_v'({9'd0, bus.wd[22:0]});
                DMA_SRC_ADR: src_q <= bus.wd;
                DMA_DST_ADR: dst_q <= bus.wd;
                default:     ;
            endcase
        end
    end

    always_comb begin
        case (reg_off)
            DMA_CR:      bus.rd = cr_q;
            DMA_SRC_ADR: bus.rd = src_q;
            DMA_DST_ADR: bus.rd = dst_q;
            default:     bus.rd = {31'd0, busy};
        endcase
    end

    dma_lane_mux u_lane_mux (
        .rd_m_i    (bus.rd_m),
        .rd_addr_i (wsrc_q[1:0]),
        .rd_size_i (wcfg_q.src_size),
        .item_i    (item_q),
        .wr_size_i (wcfg_q.dst_size),
        .item_o    (rd_item),
        .wd_m_o    (wd_rep)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wcfg_q  <= '0;
            wsrc_q  <= '0;
            wdst_q  <= '0;
            item_q  <= '0;
        end else begin
            state_q <= state_d;
            wcfg_q  <= wcfg_d;
            wsrc_q  <= wsrc_d;
            wdst_q  <= wdst_d;
            item_q  <= item_d;
        end
    end

    // Working copies decouple the running transfer from later register writes.
    always_comb begin
        state_d = state_q;
        wcfg_d  = wcfg_q;
        wsrc_d  = wsrc_q;
        wdst_d  = wdst_q;
        item_d  = item_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wd_c    = '0;
        size_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (dma_req && cr_q.line_en) begin
                    wcfg_d  = cr_q;
                    wsrc_d  = src_q;
                    wdst_d  = dst_q;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                req_c  = 1'b1;
                addr_c = wsrc_q;
                size_c = wcfg_q.src_size;
                if (bus.bus_grant) begin
                    item_d  = rd_item;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                req_c  = 1'b1;
                we_c   = 1'b1;
                addr_c = wdst_q;
                size_c = wcfg_q.dst_size;
                wd_c   = wd_rep;
                if (bus.bus_grant) begin
                    if (wcfg_q.inc_src_a) wsrc_d = wsrc_q + size_step(wcfg_q.src_size);
                    if (wcfg_q.inc_dst_a) wdst_d = wdst_q + size_step(wcfg_q.dst_size);
                    if (wcfg_q.cnt == 16'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        wcfg_d.cnt = wcfg_q.cnt - 16'd1;
                        state_d    = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.bus_req  = req_c;
    assign bus.bus_lock = req_c;
    assign bus.we_m     = we_c;
    assign bus.addr_m   = addr_c;
    assign bus.wd_m     = wd_c;
    assign bus.size_m   = size_c;
endmodule

// File: tb/tb_dma_core.sv
// Bench for dma_core: a word memory with byte enables and a grant source serve the
// master port, while a byte-level copy model predicts the resulting memory image.
`timescale 1ns/1ps
module tb_dma_core;
    import dma_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic dma_req = 1'b0;
    always #5 clk = ~clk;

    dma_core_if bus();

    dma_core dut (
        .clk     (clk),
        .rstn    (rstn),
        .dma_req (dma_req),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:511];
    logic [7:0]  exp_b [0:2047];
    logic        stall_q = 1'b0;
    logic        stall_en = 1'b0;
    logic        other_lock = 1'b0;
    logic        pl_en = 1'b0;
    logic [8:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    int unsigned req_cycles = 0;
    int unsigned grant_cycles = 0;

    assign bus.bus_grant = bus.bus_req & ~stall_q & ~other_lock;
    assign bus.rd_m      = mem[bus.addr_m[10:2]];

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    always @(posedge clk) begin
        stall_q <= stall_en && ($urandom_range(0, 2) == 0);
        if (bus.bus_req) req_cycles <= req_cycles + 1;
        if (bus.bus_req && bus.bus_grant) grant_cycles <= grant_cycles + 1;
        if (bus.bus_req && bus.bus_grant && bus.we_m) begin
            for (int k = 0; k < 4; k++)
                if (byte_en(bus.size_m, bus.addr_m[1:0])[k])
                    mem[bus.addr_m[10:2]][8*k +: 8] <= bus.wd_m[8*k +: 8];
        end
        if (pl_en) mem[pl_idx] <= pl_data;
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
        int n;
        int base;
        logic [31:0] v;
        n = nbytes(sz);
        base = int'(a & 32'h7FF) & ~(n - 1);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = exp_b[base + k];
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v);
        int n;
        int base;
        n = nbytes(sz);
        base = int'(a & 32'h7FF) & ~(n - 1);
        for (int k = 0; k < n; k++) exp_b[base + k] = v[8*k +: 8];
    endtask

    task automatic model_xfer(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                              input logic [1:0] ssz, input logic [1:0] dsz, input bit incs, input bit incd);
        logic [31:0] s;
        logic [31:0] d;
        s = src;
        d = dst;
        for (int i = 0; i <= cnt; i++) begin
            model_write(d, dsz, model_read(s, ssz));
            if (incs) s = s + nbytes(ssz);
            if (incd) d = d + nbytes(dsz);
        end
    endtask

    function automatic logic [31:0] mkcr(input int cnt, input logic [1:0] ssz, input logic [1:0] dsz,
                                         input bit incs, input bit incd, input bit en);
        return {9'd0, en, incd, incs, dsz, ssz, cnt[15:0]};
    endfunction

    // ---------------- bus helpers ----------------
    task automatic reg_write(input logic [3:0] off, input logic [31:0] d);
        @(negedge clk);
        bus.addr = {28'd0, off};
        bus.wd   = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] off, output logic [31:0] d);
        @(negedge clk);
        bus.addr = {28'd0, off};
        #1 d = bus.rd;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = a[10:2];
        pl_data = d;
        for (int k = 0; k < 4; k++) exp_b[{a[10:2], 2'b00} + k] = d[8*k +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad;
        int first;
        logic [31:0] want;
        bad = 0;
        first = -1;
        for (int w = 0; w < 512; w++) begin
            want = {exp_b[4*w+3], exp_b[4*w+2], exp_b[4*w+1], exp_b[4*w]};
            if (mem[w] !== want) begin
                if (first < 0) first = w;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            want = {exp_b[4*first+3], exp_b[4*first+2], exp_b[4*first+1], exp_b[4*first]};
            $display("FAIL %s mem: %0d words differ, first @%h got %h expected %h",
                     name, bad, first * 4, mem[first], want);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] a, input logic [31:0] want);
        checks++;
        if (mem[a[10:2]] !== want) begin
            errors++;
            $display("FAIL %s @%h: got %h expected %h", name, a, mem[a[10:2]], want);
        end
    endtask

    // One complete transfer against the model; hold = cycles another master keeps the lock.
    task automatic run_xfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int cnt, input logic [1:0] ssz, input logic [1:0] dsz,
                            input bit incs, input bit incd, input bit stall, input int hold,
                            input bit disturb);
        int unsigned r0, g0;
        int cyc;
        int unstable;
        bit done;
        bit prev_wait;
        logic [66:0] snap;
        reg_write(DMA_CR, mkcr(cnt, ssz, dsz, incs, incd, 1'b1));
        reg_write(DMA_SRC_ADR, src);
        reg_write(DMA_DST_ADR, dst);
        model_xfer(src, dst, cnt, ssz, dsz, incs, incd);
        stall_en   = stall;
        other_lock = (hold > 0);
        r0 = req_cycles;
        g0 = grant_cycles;
        @(negedge clk);
        dma_req  = 1'b1;
        bus.addr = 32'hC;
        @(posedge clk);
        #1 dma_req = 1'b0;
        checks++;
        if (!(bus.bus_req === 1'b1 && bus.bus_lock === 1'b1 && bus.we_m === 1'b0 &&
              bus.addr_m === src && bus.size_m === ssz)) begin
            errors++;
            $display("FAIL %s first_rd: req=%b lock=%b we=%b addr=%h size=%0d, expected 1 1 0 %h %0d",
                     name, bus.bus_req, bus.bus_lock, bus.we_m, bus.addr_m, bus.size_m, src, ssz);
        end
        cyc = 0;
        done = 1'b0;
        unstable = 0;
        prev_wait = 1'b0;
        snap = '0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.addr = 32'hC;
            bus.we   = 1'b0;
            dma_req  = 1'b0;
            #1;
            if (prev_wait && {bus.bus_req, bus.bus_lock, bus.we_m, bus.addr_m, bus.wd_m} !== snap)
                unstable++;
            snap = {bus.bus_req, bus.bus_lock, bus.we_m, bus.addr_m, bus.wd_m};
            if (bus.rd[0] === 1'b0) done = 1'b1;
            if (cyc >= hold) other_lock = 1'b0;
            if (disturb && cyc == 1) begin
                dma_req  = 1'b1;
                bus.we   = 1'b1;
                bus.addr = 32'h4;
                bus.wd   = 32'h0000_07C0;
            end
            prev_wait = bus.bus_req && (stall_q || other_lock);
        end
        dma_req  = 1'b0;
        bus.we   = 1'b0;
        stall_en = 1'b0;
        other_lock = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles, expected 0", name, cyc);
        end
        checks++;
        if (grant_cycles - g0 != 2 * (cnt + 1)) begin
            errors++;
            $display("FAIL %s grants: got %0d expected %0d", name, grant_cycles - g0, 2 * (cnt + 1));
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL %s stable: %0d wait cycles changed outputs, expected 0", name, unstable);
        end
        if (!stall && hold == 0) begin
            checks++;
            if (req_cycles - r0 != 2 * (cnt + 1)) begin
                errors++;
                $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cycles - r0, 2 * (cnt + 1));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_req: got %b expected 0", name, bus.bus_req);
        end
        check_mem(name);
        $display("xfer %s src=%h dst=%h cnt=%0d ssz=%0d dsz=%0d incs=%0b incd=%0b grants=%0d cycles=%0d",
                 name, src, dst, cnt, ssz, dsz, incs, incd, grant_cycles - g0, cyc);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] v;
        bus.addr = '0; bus.we = 1'b0; bus.wd = '0; bus.size = 2'b10;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.bus_req, bus.bus_lock, bus.we_m, bus.addr_m, bus.wd_m, bus.size_m} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b lock=%b we=%b addr=%h wd=%h size=%0d, expected all 0",
                     bus.bus_req, bus.bus_lock, bus.we_m, bus.addr_m, bus.wd_m, bus.size_m);
        end
        rstn = 1'b1;
        for (int r = 0; r < 4; r++) begin
            reg_read(4'(r * 4), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 00000000", r, v);
            end
        end
    endtask

    task automatic test_regs;
        logic [31:0] v;
        reg_write(DMA_CR, 32'h0070_000A);
        reg_write(DMA_SRC_ADR, 32'h100);
        reg_write(DMA_DST_ADR, 32'h200);
        reg_write(DMA_SR, 32'hFFFF_FFFF);
        reg_read(DMA_CR, v);
        checks++; if (v !== 32'h0070_000A) begin errors++; $display("FAIL regs_cr: got %h expected 0070000a", v); end
        reg_read(DMA_SRC_ADR, v);
        checks++; if (v !== 32'h100) begin errors++; $display("FAIL regs_src: got %h expected 00000100", v); end
        reg_read(DMA_DST_ADR, v);
        checks++; if (v !== 32'h200) begin errors++; $display("FAIL regs_dst: got %h expected 00000200", v); end
        reg_read(DMA_SR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL regs_sr: got %h expected 00000000", v); end
        reg_write(DMA_CR, 32'hFFFF_FFFF);
        reg_read(DMA_CR, v);
        checks++; if (v !== 32'h007F_FFFF) begin errors++; $display("FAIL regs_cr_rsv: got %h expected 007fffff", v); end
        reg_write(DMA_CR, 32'h0);
        $display("xfer regs readback done");
    endtask

    task automatic init_mem;
        for (int w = 0; w < 512; w++) preload(32'(w * 4), $urandom);
    endtask

    task automatic test_word_copy;
        preload(32'h1FC, 32'hFEED_FACE);
        preload(32'h20C, 32'h0BAD_F00D);
        preload(32'h100, 32'h1122_3344);
        preload(32'h104, 32'h5566_7788);
        preload(32'h108, 32'h99AA_BBCC);
        run_xfer("word_copy", 32'h100, 32'h200, 2, SZ_W, SZ_W, 1, 1, 0, 0, 0);
        check_word("wc0", 32'h200, 32'h1122_3344);
        check_word("wc2", 32'h208, 32'h99AA_BBCC);
        check_word("wc_below", 32'h1FC, 32'hFEED_FACE);
        check_word("wc_above", 32'h20C, 32'h0BAD_F00D);
    endtask

    task automatic test_byte_to_word;
        preload(32'h300, 32'h44B2_A133);
        run_xfer("byte_to_word", 32'h301, 32'h400, 1, SZ_B, SZ_W, 1, 1, 0, 0, 0);
        check_word("b2w0", 32'h400, 32'h0000_00A1);
        check_word("b2w1", 32'h404, 32'h0000_00B2);
    endtask

    task automatic test_word_to_half;
        preload(32'h500, 32'hDEAD_BEEF);
        preload(32'h504, 32'hCAFE_F00D);
        preload(32'h600, 32'h1234_5678);
        preload(32'h604, 32'h9999_0000);
        run_xfer("word_to_half", 32'h500, 32'h602, 1, SZ_W, SZ_H, 1, 1, 0, 0, 0);
        check_word("w2h0", 32'h600, 32'hBEEF_5678);
        check_word("w2h1", 32'h604, 32'h9999_F00D);
    endtask

    task automatic test_line_en_off;
        int unsigned r0;
        logic [31:0] v;
        reg_write(DMA_CR, mkcr(3, SZ_W, SZ_W, 1, 1, 1'b0));
        reg_write(DMA_SRC_ADR, 32'h100);
        reg_write(DMA_DST_ADR, 32'h700);
        r0 = req_cycles;
        @(negedge clk); dma_req = 1'b1;
        @(posedge clk); #1 dma_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (req_cycles != r0) begin
            errors++;
            $display("FAIL line_en_off req_cycles: got %0d expected 0", req_cycles - r0);
        end
        reg_read(DMA_SR, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL line_en_off sr: got %h expected 00000000", v); end
        check_mem("line_en_off");
        $display("xfer line_en_off req_cycles=%0d", req_cycles - r0);
    endtask

    task automatic test_busy_req;
        run_xfer("busy_req", 32'h140, 32'h480, 3, SZ_W, SZ_W, 1, 1, 0, 0, 1);
    endtask

    task automatic test_no_inc_src;
        preload(32'h180, 32'h0F1E_2D3C);
        run_xfer("no_inc_src", 32'h180, 32'h700, 3, SZ_W, SZ_W, 0, 1, 0, 0, 0);
        check_word("nis3", 32'h70C, 32'h0F1E_2D3C);
    endtask

    task automatic test_contention;
        run_xfer("contention", 32'h1C0, 32'h540, 2, SZ_H, SZ_H, 1, 1, 0, 6, 0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 10; t++) begin
            logic [1:0] ssz, dsz;
            logic [31:0] src, dst;
            int cnt;
            ssz = 2'($urandom_range(0, 3));
            dsz = 2'($urandom_range(0, 3));
            cnt = $urandom_range(0, 7);
            src = 32'($urandom_range(0, 32'h2FF)) & ~32'(nbytes(ssz) - 1);
            dst = 32'h400 + (32'($urandom_range(0, 32'h2FF)) & ~32'(nbytes(dsz) - 1));
            run_xfer($sformatf("rand%0d", t), src, dst, cnt, ssz, dsz,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        reg_write(DMA_CR, mkcr(20, SZ_W, SZ_W, 1, 1, 1'b1));
        reg_write(DMA_SRC_ADR, 32'h100);
        reg_write(DMA_DST_ADR, 32'h600);
        @(negedge clk); dma_req = 1'b1;
        @(posedge clk); #1 dma_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.bus_req !== 1'b0 || bus.bus_lock !== 1'b0 || bus.we_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid bus: req=%b lock=%b we=%b expected 0 0 0", bus.bus_req, bus.bus_lock, bus.we_m);
        end
        for (int r = 0; r < 4; r++) begin
            reg_read(4'(r * 4), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid reg%0d: got %h expected 00000000", r, v);
            end
        end
        @(negedge clk); rstn = 1'b1;
        $display("xfer reset_mid done");
    endtask

    initial begin
        test_reset();
        test_regs();
        init_mem();
        test_word_copy();
        test_byte_to_word();
        test_word_to_half();
        test_line_en_off();
        test_busy_req();
        test_no_inc_src();
        test_contention();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
